// File: rtl/regfile_onehot.sv
// 32-entry register file with a one-hot write select, two combinational read ports and a sticky select-error flag.
// Optional build macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_onehot #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [31:0]       wr_sel_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic              sel_err_o
);

  // The write select is a fixed 32-bit one-hot vector, so the register count cannot vary.
  if (NREG != 32) begin : g_nreg_check
    $error("regfile_onehot: NREG must be 32");
  end

  // x0 has no storage; only x1..x31 exist as flops.
  logic [DATA_W-1:0] regs [1:NREG-1];
  logic [DATA_W-1:0] xr   [NREG];
  logic              multi_hot;

  // NOTE: the storage is built from flops and is cleared by the async reset, which
  // makes every register's power-up value deterministic and discards any write on a
  // clock edge that lands while reset is held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 1; k < NREG; k++) begin
        regs[k] <= '0;
      end
    end else if (wr_en_i) begin
      for (int k = 1; k < NREG; k++) begin
        if (wr_sel_i[k]) begin
          regs[k] <= wr_data_i;
        end
      end
    end
  end

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign multi_hot = |(wr_sel_i & (wr_sel_i - 32'd1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_err_o <= 1'b0;
    end else if (wr_en_i && multi_hot) begin
      sel_err_o <= 1'b1;
    end
  end

  // Full 32-entry view so a 5-bit address indexes it directly, with x0 tied to zero.
  always_comb begin
    xr[0] = '0;
    for (int k = 1; k < NREG; k++) begin
      xr[k] = regs[k];
    end
  end

  // NOTE: combinational read logic assigns a default first on every path, so no
  // latch is inferred when the forwarding condition is false.
  always_comb begin
    rs1_data_o = xr[rs1_addr_i];
    rs2_data_o = xr[rs2_addr_i];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by reset so the read ports stay zero while rst_ni is low.
    if (rst_ni && wr_en_i && (rs1_addr_i != 5'd0) && wr_sel_i[rs1_addr_i]) begin
      rs1_data_o = wr_data_i;
    end
    if (rst_ni && wr_en_i && (rs2_addr_i != 5'd0) && wr_sel_i[rs2_addr_i]) begin
      rs2_data_o = wr_data_i;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_onehot.sv
// Self-checking bench for regfile_onehot: directed vector table, corner-case sequences and
// randomized traffic against an array-based reference model.
module tb_regfile_onehot;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_sel;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_regs [32];
  logic        model_err;

  regfile_onehot #(.DATA_W(32), .NREG(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_en_i    (wr_en),
    .wr_sel_i   (wr_sel),
    .wr_data_i  (wr_data),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .sel_err_o  (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic [31:0] sel;
    logic [31:0] data;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eerr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 32; k++) model_regs[k] = '0;
    model_err = 1'b0;
  endfunction

  // A write loads every selected register above x0; two or more select bits is an error.
  function automatic void model_write(input logic en, input logic [31:0] sel, input logic [31:0] d);
    if (en) begin
      for (int k = 1; k < 32; k++) if (sel[k]) model_regs[k] = d;
      if ($countones(sel) > 1) model_err = 1'b1;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic en,
                                             input logic [31:0] sel, input logic [31:0] d);
    if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (en && sel[a]) return d;
`endif
    return model_regs[a];
  endfunction

  initial begin
    logic [31:0] exp_same;
    logic [31:0] rsel;
    logic [31:0] rdata;
    logic        ren;
    int          kind;

    vecs[0] = '{"wr x10",       1'b1, 32'h0000_0400, 32'h1234_5678, 5'd10, 5'd10, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[1] = '{"wr x0",        1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  5'd10, 32'h0000_0000, 32'h1234_5678, 1'b0};
    vecs[2] = '{"gate off",     1'b0, 32'hFFFF_FFFF, 32'h0000_0099, 5'd10, 5'd5,  32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[3] = '{"zero sel",     1'b1, 32'h0000_0000, 32'h0000_0077, 5'd10, 5'd3,  32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[4] = '{"wr x5",        1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 5'd5,  5'd10, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
    vecs[5] = '{"multi x1 x31", 1'b1, 32'h8000_0006, 32'hA5A5_A5A5, 5'd1,  5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1};
    vecs[6] = '{"multi x2",     1'b0, 32'h0000_0000, 32'h0000_0000, 5'd2,  5'd5,  32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b1};
    vecs[7] = '{"x0 plus x3",   1'b1, 32'h0000_0009, 32'h0000_0033, 5'd3,  5'd0,  32'h0000_0033, 32'h0000_0000, 1'b1};

    rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rs1_addr = 5'd5; rs2_addr = 5'd31;
    model_reset();
    #2;
    check("reset rs1", rs1_data, 32'h0);
    check("reset rs2", rs2_data, 32'h0);
    check("reset sel_err", {31'd0, sel_err}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = vecs[i].en; wr_sel = vecs[i].sel; wr_data = vecs[i].data;
      @(posedge clk);
      model_write(vecs[i].en, vecs[i].sel, vecs[i].data);
      #1;
      wr_en = 1'b0; rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2;
      #1;
      check($sformatf("%s rs1", vecs[i].name), rs1_data, vecs[i].e1);
      check($sformatf("%s rs2", vecs[i].name), rs2_data, vecs[i].e2);
      check($sformatf("%s sel_err", vecs[i].name), {31'd0, sel_err}, {31'd0, vecs[i].eerr});
    end

    // Same-cycle read of a register being written, and no forwarding from x0.
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 32'h80; wr_data = 32'h11;
    @(posedge clk); model_write(1'b1, 32'h80, 32'h11);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 32'h81; wr_data = 32'h22; rs1_addr = 5'd7; rs2_addr = 5'd0;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    #1;
    check("same-cycle rs1 x7", rs1_data, exp_same);
    check("same-cycle rs2 x0", rs2_data, 32'h0);
    @(posedge clk); model_write(1'b1, 32'h81, 32'h22);
    #1;
    wr_en = 1'b0;
    #1;
    check("after write rs1 x7", rs1_data, 32'h22);
    repeat (3) @(posedge clk);
    #1;
    check("sticky sel_err", {31'd0, sel_err}, 32'h1);

    // Mid-cycle asynchronous reset, with a write attempted across an edge during reset.
    @(negedge clk);
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    check("pre-reset x5", rs1_data, 32'hDEAD_BEEF);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset rs1", rs1_data, 32'h0);
    check("async reset sel_err", {31'd0, sel_err}, 32'h0);
    wr_en = 1'b1; wr_sel = 32'h20; wr_data = 32'h5555_0001;
    #1;
    check("reset no forward rs2", rs2_data, 32'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("post-reset x5", rs1_data, 32'h0);
    rs2_addr = 5'd31;
    #1;
    check("post-reset x31", rs2_data, 32'h0);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = 32'h20; wr_data = 32'hCAFE_0005;
    @(posedge clk); model_write(1'b1, 32'h20, 32'hCAFE_0005);
    #1; wr_en = 1'b0; #1;
    check("resume write x5", rs1_data, 32'hCAFE_0005);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      kind  = int'($urandom_range(0, 19));
      ren   = ($urandom_range(0, 3) != 0);
      rdata = $urandom;
      if (kind == 0)       rsel = '0;
      else if (kind == 19) rsel = $urandom | (32'h1 << $urandom_range(0, 31)) | 32'h1000_0000;
      else                 rsel = 32'h1 << $urandom_range(0, 31);
      wr_en = ren; wr_sel = rsel; wr_data = rdata;
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = (it % 5 == 0) ? rs1_addr : 5'($urandom_range(0, 31));
      #1;
      check("rand rs1", rs1_data, model_read(rs1_addr, ren, rsel, rdata));
      check("rand rs2", rs2_data, model_read(rs2_addr, ren, rsel, rdata));
      @(posedge clk);
      model_write(ren, rsel, rdata);
      #1;
      check("rand sel_err", {31'd0, sel_err}, {31'd0, model_err});
    end

    @(negedge clk);
    wr_en = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rs1_addr = 5'(k);
      #1;
      check($sformatf("final x%0d", k), rs1_data, model_regs[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_onehot.md
REGFILE_ONEHOT -- requirements
Module: regfile_onehot

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width.
REQ-002 The block SHALL have parameter NREG, default 32, giving the register count; NREG SHALL be fixed at 32 to match the one-hot select width.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port wr_en_i, input, 1 bit: global write enable.
REQ-006 The block SHALL have port wr_sel_i, input, 32 bits: one-hot write-register select from the upstream 5-to-32 decoder.
REQ-007 The block SHALL have port wr_data_i, input, DATA_W bits: write data.
REQ-008 The block SHALL have port rs1_addr_i, input, 5 bits: read port 1 address.
REQ-009 The block SHALL have port rs2_addr_i, input, 5 bits: read port 2 address.
REQ-010 The block SHALL have port rs1_data_o, output, DATA_W bits: read port 1 data.
REQ-011 The block SHALL have port rs2_data_o, output, DATA_W bits: read port 2 data.
REQ-012 The block SHALL have port sel_err_o, output, 1 bit: sticky flag for a non-one-hot select seen while wr_en_i=1.

Function
REQ-013 Storage SHALL be registers x0..x31, each DATA_W wide; x0 SHALL read as zero always and SHALL never be written.
REQ-014 On a rising clk_i with wr_en_i=1, every register xk (k=1..31) with wr_sel_i[k]=1 SHALL load wr_data_i; all others SHALL hold.
REQ-015 wr_sel_i[0] SHALL be ignored for storage.
REQ-016 wr_en_i=0 SHALL block all writes regardless of wr_sel_i.
REQ-017 wr_sel_i=0 with wr_en_i=1 SHALL write nothing and SHALL NOT set sel_err_o.
REQ-018 A select with two or more bits set and wr_en_i=1 SHALL write every selected register (k>=1) in the same cycle.
REQ-019 That same case SHALL set sel_err_o on that clock edge; sel_err_o SHALL stay 1 until reset.
REQ-020 Reads SHALL be combinational: rs1_data_o = x[rs1_addr_i] and rs2_data_o = x[rs2_addr_i], zero-latency from address change.
REQ-021 Both ports MAY address the same register and SHALL then return identical data.
REQ-022 A write SHALL be visible on the read ports in the cycle after the write edge (one-cycle write latency).

Reset
REQ-023 rst_ni=0 SHALL asynchronously clear x1..x31 to 0 and sel_err_o to 0, independent of clk_i.
REQ-024 While rst_ni=0, both read ports SHALL output 0 and no write SHALL occur.
REQ-025 A write whose clock edge coincides with an asserted rst_ni SHALL be discarded.
REQ-026 Normal operation SHALL resume on the first rising clk_i after rst_ni deasserts.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With REGFILE_BYPASS_EN defined, a read address k>=1 with wr_en_i=1 and wr_sel_i[k]=1 in the same cycle SHALL return wr_data_i combinationally instead of the stored value.
REQ-029 Without REGFILE_BYPASS_EN, reads SHALL always return the stored (pre-write) value.
REQ-030 Forwarding SHALL never apply to x0 in either build.

Verification
REQ-031 Reset test: assert rst_ni=0 mid-run after writing x5=0xDEADBEEF -> rs1_data_o=0 immediately and sel_err_o=0; after release, a read of x5 returns 0.
REQ-032 Write/read test: wr_en_i=1, wr_sel_i=0x0000_0400, wr_data_i=0x1234_5678, one edge, then rs1_addr_i=10 and rs2_addr_i=10 -> both outputs 0x1234_5678.
REQ-033 x0 test: wr_en_i=1, wr_sel_i=0x0000_0001, wr_data_i=0xFFFF_FFFF -> rs1_addr_i=0 reads 0 and sel_err_o=0.
REQ-034 Multi-hot test: wr_en_i=1, wr_sel_i=0x8000_0006, wr_data_i=0xA5A5_A5A5 -> x1, x2 and x31 all read 0xA5A5_A5A5 and sel_err_o=1, held until reset.
REQ-035 Same-cycle read test: x7=0x11, then wr_sel_i=0x80, wr_data_i=0x22, wr_en_i=1, rs1_addr_i=7 before the edge -> rs1_data_o=0x22 with REGFILE_BYPASS_EN, 0x11 without.
REQ-036 Write-gate test: wr_en_i=0, wr_sel_i=0xFFFF_FFFF, wr_data_i=0x99 -> no register changes and sel_err_o remains 0.
